conv_fc_sequencer: RTL and testbench
====================================

Name: conv_fc_sequencer

Overview:
- Frame-level controller that sequences the convolution datapath and then the fully-connected datapath for one image.
- Accepts a frame over the upstream valid/ready handshake.
- Issues one conv window request per output pixel in raster order, then issues one FC beat per (neuron, feature) pair.
- Presents completion over the downstream valid/ready handshake. Sits between the top-level handshake and the conv/FC compute engines.

Parameters:
- IMG_W, 28, input image width and height (square).
- K, 3, conv kernel size; OUT_W = IMG_W-K+1 (derived localparam; 26 by default).
- N_OUT, 10, number of FC neurons.
- Derived localparams: N_FEAT = OUT_W*OUT_W (676); RC_W = $clog2(OUT_W); F_W = $clog2(N_FEAT); N_W = $clog2(N_OUT).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pre_valid  in  1  upstream frame available.
- o_pre_ready  out  1  sequencer can accept a frame.
- o_post_valid  out  1  results of the current frame are complete.
- i_post_ready  in  1  downstream consumes the results.
- o_frame_start  out  1  one-cycle pulse on frame accept; engines clear their state.
- o_conv_vld  out  1  conv window request valid.
- i_conv_rdy  in  1  conv engine accepts the window.
- o_conv_row  out  RC_W  window top-left row.
- o_conv_col  out  RC_W  window top-left col.
- o_fc_vld  out  1  FC beat valid.
- i_fc_rdy  in  1  FC engine accepts the beat.
- o_fc_neuron  out  N_W  neuron index.
- o_fc_feat  out  F_W  feature index (= row*OUT_W+col).
- o_fc_first  out  1  beat is feature 0 (accumulator loads bias).
- o_fc_last  out  1  beat is feature N_FEAT-1 (accumulator result final).
- o_busy  out  1  state is not IDLE.

Behaviour:
- FSM states: IDLE, CONV, FC, DONE. All state and counters are reset asynchronously by i_rst to IDLE/0.
- Reset values:
  - o_pre_ready=1, since it is decoded as state==IDLE.
  - All other outputs 0: o_frame_start, o_conv_vld, o_fc_vld, o_post_valid, o_busy, indices, first/last.
- Reset asserted mid-frame aborts immediately to IDLE. No partial o_post_valid is ever produced.
- IDLE:
  - o_pre_ready=1.
  - On i_pre_valid&&o_pre_ready at a rising edge: state->CONV, row=col=0, o_frame_start=1 for exactly the next cycle.
- CONV:
  - o_conv_vld=1, with o_conv_row/col driven from the counters.
  - On i_conv_vld&&i_conv_rdy: col++. At col==OUT_W-1, col wraps to 0 and row++.
  - On acceptance of (OUT_W-1,OUT_W-1): state->FC, n=f=0.
  - While vld&&!rdy, row/col hold stable and o_conv_vld stays 1.
- FC:
  - o_fc_vld=1, with o_fc_first=(f==0) and o_fc_last=(f==N_FEAT-1).
  - Feature is the inner loop and neuron the outer loop.
  - On o_fc_vld&&i_fc_rdy: f++. At f==N_FEAT-1, f wraps to 0 and n++.
  - On acceptance of (N_OUT-1, N_FEAT-1): state->DONE.
  - Indices hold while stalled.
- DONE:
  - o_post_valid=1, held until i_post_ready is sampled high; then state->IDLE.
  - o_post_valid is never dropped without the handshake.
- o_conv_vld and o_fc_vld are never high in the same cycle.
- o_pre_ready=0 in CONV/FC/DONE. i_pre_valid is ignored there; no queuing.
- Latency with all readies held high:
  - Accept edge E0; conv beats accepted E1..E676; FC beats E677..E7436.
  - o_post_valid is high in the cycle after E7436 (7436 edges after accept in the default configuration).
  - If i_post_ready=1, o_pre_ready returns high one cycle after that.
- Counters are exact widths with explicit wrap compares; no overflow wrap is relied on.

Test Plan:
1. i_rst pulse (high 15 ns), all readies=1, i_pre_valid=1 -> o_frame_start single pulse. Conv beats in raster order, first (0,0), 676th (25,25). FC beats 6760 total, first (n0,f0), last (n9,f675). o_post_valid rises exactly 7436 edges after accept.
2. Random 50% i_conv_rdy/i_fc_rdy -> identical index sequence to scenario 1. Indices and vld stable on every stalled cycle; beat counts 676 and 6760.
3. FC phase check -> o_fc_first count=10 and o_fc_last count=10, each coinciding with f=0 and f=675 respectively. o_conv_vld and o_fc_vld never both 1.
4. i_post_ready low for 20 cycles in DONE -> o_post_valid held 20+ cycles and o_pre_ready=0. After the handshake, state returns to IDLE; a back-to-back i_pre_valid is accepted one cycle later.
5. i_rst asserted asynchronously (between edges) at FC beat n=4,f=300 -> all outputs take reset values immediately, o_pre_ready=1, no o_post_valid. A new frame then runs complete from (0,0).
6. IMG_W=6, N_OUT=2 -> 16 conv beats ending at (3,3), 32 FC beats ending at (n1,f15), o_post_valid 48 edges after accept.

Source files
------------

// File: rtl/conv_fc_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_fc_sequencer
//
// Frame-level controller for one image. It accepts a frame on the upstream
// handshake and then drives the two compute engines in turn:
//   1. the convolution engine gets one window request per output pixel, in
//      raster order (row outer, column inner);
//   2. the fully-connected engine gets one beat per (neuron, feature) pair,
//      with the feature as the inner loop and the neuron as the outer loop.
// When the last FC beat has been accepted, completion is held on the
// downstream handshake until it is consumed. The block then returns to idle.
//
// Ports
//   i_clk, i_rst        clock (rising edge); asynchronous active-high reset
//   i_pre_valid         upstream has a frame
//   o_pre_ready         sequencer is idle and can take a frame
//   o_post_valid        results of the current frame are complete
//   i_post_ready        downstream consumes the results
//   o_frame_start       one-cycle pulse after a frame is accepted
//   o_conv_vld          conv window request valid
//   i_conv_rdy          conv engine accepts the window
//   o_conv_row/col      window top-left row / column
//   o_fc_vld            FC beat valid
//   i_fc_rdy            FC engine accepts the beat
//   o_fc_neuron         neuron index of the beat
//   o_fc_feat           feature index of the beat (= row*OUT_W + col)
//   o_fc_first          beat carries feature 0 (accumulator loads bias)
//   o_fc_last           beat carries the last feature (result is final)
//   o_busy              a frame is in progress
// -----------------------------------------------------------------------------
module conv_fc_sequencer #(
    parameter  int IMG_W  = 28,
    parameter  int K      = 3,
    parameter  int N_OUT  = 10,
    localparam int OUT_W  = IMG_W - K + 1,
    localparam int N_FEAT = OUT_W * OUT_W,
    // Guards keep every index at least one bit wide for degenerate sizes.
    localparam int RC_W   = (OUT_W  > 1) ? $clog2(OUT_W)  : 1,
    localparam int F_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int N_W    = (N_OUT  > 1) ? $clog2(N_OUT)  : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pre_valid,
    output logic            o_pre_ready,
    output logic            o_post_valid,
    input  logic            i_post_ready,
    output logic            o_frame_start,
    output logic            o_conv_vld,
    input  logic            i_conv_rdy,
    output logic [RC_W-1:0] o_conv_row,
    output logic [RC_W-1:0] o_conv_col,
    output logic            o_fc_vld,
    input  logic            i_fc_rdy,
    output logic [N_W-1:0]  o_fc_neuron,
    output logic [F_W-1:0]  o_fc_feat,
    output logic            o_fc_first,
    output logic            o_fc_last,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FC,
        S_DONE
    } state_t;

    // Terminal values of each counter; every wrap is an explicit compare so
    // nothing depends on a counter overflowing naturally.
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(OUT_W - 1);
    localparam logic [F_W-1:0]  F_LAST   = F_W'(N_FEAT - 1);
    localparam logic [F_W-1:0]  F_PENULT = F_W'((N_FEAT > 1) ? N_FEAT - 2 : 0);
    localparam logic [N_W-1:0]  N_LAST   = N_W'(N_OUT - 1);
    localparam logic            ONE_FEAT = (N_FEAT == 1);

    state_t          r_state;
    logic [RC_W-1:0] r_row;
    logic [RC_W-1:0] r_col;
    logic [N_W-1:0]  r_n;
    logic [F_W-1:0]  r_f;
    logic            r_pre_ready;
    logic            r_post_valid;
    logic            r_frame_start;
    logic            r_conv_vld;
    logic            r_fc_vld;
    logic            r_fc_first;
    logic            r_fc_last;
    logic            r_busy;

    // Every output is a flop: the state transition that changes the state
    // also sets the matching output flags, so outputs and state never skew.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_n           <= '0;
            r_f           <= '0;
            r_pre_ready   <= 1'b1;
            r_post_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_conv_vld    <= 1'b0;
            r_fc_vld      <= 1'b0;
            r_fc_first    <= 1'b0;
            r_fc_last     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in this block; a later
            // assignment in the same cycle overrides this default pulse clear.
            r_frame_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_pre_valid) begin
                        r_state       <= S_CONV;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_frame_start <= 1'b1;
                        r_conv_vld    <= 1'b1;
                        r_pre_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                // r_conv_vld is high throughout CONV, so a ready alone is a
                // completed handshake. Without ready the indices simply hold.
                S_CONV: begin
                    if (i_conv_rdy) begin
                        if (r_col == RC_LAST) begin
                            r_col <= '0;
                            if (r_row == RC_LAST) begin
                                // Last window accepted: hand over to FC.
                                r_row      <= '0;
                                r_state    <= S_FC;
                                r_conv_vld <= 1'b0;
                                r_fc_vld   <= 1'b1;
                                r_n        <= '0;
                                r_f        <= '0;
                                r_fc_first <= 1'b1;
                                r_fc_last  <= ONE_FEAT;
                            end else begin
                                r_row <= r_row + RC_W'(1);
                            end
                        end else begin
                            r_col <= r_col + RC_W'(1);
                        end
                    end
                end

                // first/last are precomputed for the next feature index so
                // they are registered alongside it.
                S_FC: begin
                    if (i_fc_rdy) begin
                        if (r_f == F_LAST) begin
                            r_f <= '0;
                            if (r_n == N_LAST) begin
                                r_n          <= '0;
                                r_state      <= S_DONE;
                                r_fc_vld     <= 1'b0;
                                r_fc_first   <= 1'b0;
                                r_fc_last    <= 1'b0;
                                r_post_valid <= 1'b1;
                            end else begin
                                r_n        <= r_n + N_W'(1);
                                r_fc_first <= 1'b1;
                                r_fc_last  <= ONE_FEAT;
                            end
                        end else begin
                            r_f        <= r_f + F_W'(1);
                            r_fc_first <= 1'b0;
                            r_fc_last  <= (r_f == F_PENULT);
                        end
                    end
                end

                // Completion is only withdrawn by the handshake.
                S_DONE: begin
                    if (i_post_ready) begin
                        r_state      <= S_IDLE;
                        r_post_valid <= 1'b0;
                        r_pre_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pre_ready   = r_pre_ready;
    assign o_post_valid  = r_post_valid;
    assign o_frame_start = r_frame_start;
    assign o_conv_vld    = r_conv_vld;
    assign o_conv_row    = r_row;
    assign o_conv_col    = r_col;
    assign o_fc_vld      = r_fc_vld;
    assign o_fc_neuron   = r_n;
    assign o_fc_feat     = r_f;
    assign o_fc_first    = r_fc_first;
    assign o_fc_last     = r_fc_last;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_conv_fc_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for conv_fc_sequencer. Two instances share the input
// stimulus: the default-size one and a small one (IMG_W=6, N_OUT=2). A select
// picks which instance's outputs the checks observe. Expected behaviour comes
// from a beat-counting model: the conv index of beat i is (i/OUT_W, i%OUT_W),
// the FC index of beat j is (j/N_FEAT, j%N_FEAT).
module tb_conv_fc_sequencer;

    localparam int B_IMG  = 28;
    localparam int B_K    = 3;
    localparam int B_NOUT = 10;
    localparam int B_OW   = B_IMG - B_K + 1;
    localparam int B_NF   = B_OW * B_OW;
    localparam int B_RCW  = $clog2(B_OW);
    localparam int B_FW   = $clog2(B_NF);
    localparam int B_NW   = $clog2(B_NOUT);
    localparam int S_IMG  = 6;
    localparam int S_NOUT = 2;
    localparam int S_OW   = S_IMG - B_K + 1;
    localparam int S_NF   = S_OW * S_OW;
    localparam int S_RCW  = $clog2(S_OW);
    localparam int S_FW   = $clog2(S_NF);
    localparam int S_NW   = $clog2(S_NOUT);

    logic clk, rst, pre_valid, post_ready, conv_rdy, fc_rdy, sel;
    int   n_checks, n_errors;

    logic b_pre_ready, b_post_valid, b_frame_start, b_conv_vld, b_fc_vld;
    logic b_fc_first, b_fc_last, b_busy;
    logic [B_RCW-1:0] b_row, b_col;
    logic [B_NW-1:0]  b_n;
    logic [B_FW-1:0]  b_f;

    logic s_pre_ready, s_post_valid, s_frame_start, s_conv_vld, s_fc_vld;
    logic s_fc_first, s_fc_last, s_busy;
    logic [S_RCW-1:0] s_row, s_col;
    logic [S_NW-1:0]  s_n;
    logic [S_FW-1:0]  s_f;

    logic [31:0] p_pre_ready, p_post_valid, p_frame_start, p_conv_vld, p_fc_vld;
    logic [31:0] p_fc_first, p_fc_last, p_busy, p_row, p_col, p_n, p_f;

    conv_fc_sequencer #(.IMG_W(B_IMG), .K(B_K), .N_OUT(B_NOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pre_valid(pre_valid), .o_pre_ready(b_pre_ready),
        .o_post_valid(b_post_valid), .i_post_ready(post_ready),
        .o_frame_start(b_frame_start),
        .o_conv_vld(b_conv_vld), .i_conv_rdy(conv_rdy),
        .o_conv_row(b_row), .o_conv_col(b_col),
        .o_fc_vld(b_fc_vld), .i_fc_rdy(fc_rdy),
        .o_fc_neuron(b_n), .o_fc_feat(b_f),
        .o_fc_first(b_fc_first), .o_fc_last(b_fc_last),
        .o_busy(b_busy)
    );

    conv_fc_sequencer #(.IMG_W(S_IMG), .K(B_K), .N_OUT(S_NOUT)) dut_small (
        .i_clk(clk), .i_rst(rst),
        .i_pre_valid(pre_valid), .o_pre_ready(s_pre_ready),
        .o_post_valid(s_post_valid), .i_post_ready(post_ready),
        .o_frame_start(s_frame_start),
        .o_conv_vld(s_conv_vld), .i_conv_rdy(conv_rdy),
        .o_conv_row(s_row), .o_conv_col(s_col),
        .o_fc_vld(s_fc_vld), .i_fc_rdy(fc_rdy),
        .o_fc_neuron(s_n), .o_fc_feat(s_f),
        .o_fc_first(s_fc_first), .o_fc_last(s_fc_last),
        .o_busy(s_busy)
    );

    always_comb begin
        if (sel) begin
            p_pre_ready = 32'(s_pre_ready);   p_post_valid = 32'(s_post_valid);
            p_frame_start = 32'(s_frame_start); p_conv_vld = 32'(s_conv_vld);
            p_fc_vld = 32'(s_fc_vld);         p_fc_first = 32'(s_fc_first);
            p_fc_last = 32'(s_fc_last);       p_busy = 32'(s_busy);
            p_row = 32'(s_row); p_col = 32'(s_col); p_n = 32'(s_n); p_f = 32'(s_f);
        end else begin
            p_pre_ready = 32'(b_pre_ready);   p_post_valid = 32'(b_post_valid);
            p_frame_start = 32'(b_frame_start); p_conv_vld = 32'(b_conv_vld);
            p_fc_vld = 32'(b_fc_vld);         p_fc_first = 32'(b_fc_first);
            p_fc_last = 32'(b_fc_last);       p_busy = 32'(b_busy);
            p_row = 32'(b_row); p_col = 32'(b_col); p_n = 32'(b_n); p_f = 32'(b_f);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pre_ready"},   p_pre_ready,   1);
        check({tag, " post_valid"},  p_post_valid,  0);
        check({tag, " frame_start"}, p_frame_start, 0);
        check({tag, " conv_vld"},    p_conv_vld,    0);
        check({tag, " fc_vld"},      p_fc_vld,      0);
        check({tag, " busy"},        p_busy,        0);
        check({tag, " row"},         p_row,         0);
        check({tag, " col"},         p_col,         0);
        check({tag, " neuron"},      p_n,           0);
        check({tag, " feat"},        p_f,           0);
        check({tag, " first"},       p_fc_first,    0);
        check({tag, " last"},        p_fc_last,     0);
    endtask

    // Runs one frame starting at a negedge with the DUT idle. pct is the
    // percentage of cycles with engine readies high; post_stall is the number
    // of completion cycles before i_post_ready rises; abort_fi >= 0 fires an
    // asynchronous reset while FC beat number abort_fi is being presented.
    task automatic run_frame(input string nm, input int ow, input int nout,
                             input int pct, input int post_stall, input int abort_fi);
        int  nc, nfeat, nf, ci, fi, budget, starts, firsts, lasts, post_cnt, first_post_k;
        bit  hs_done, finished, exp_post;
        nc = ow * ow; nfeat = nc; nf = nout * nfeat;
        ci = 0; fi = 0; starts = 0; firsts = 0; lasts = 0; post_cnt = 0;
        first_post_k = -1; hs_done = 0; finished = 0;
        budget = (nc + nf) * 6 + post_stall + 20;

        check({nm, " idle pre_ready"}, p_pre_ready, 1);
        check({nm, " idle busy"}, p_busy, 0);
        pre_valid  = 1'b1;   // held through the frame: must be ignored while busy
        post_ready = 1'b0;
        conv_rdy   = ($urandom_range(99) < 32'(pct));
        fc_rdy     = ($urandom_range(99) < 32'(pct));

        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            exp_post = (ci == nc) && (fi == nf) && !hs_done;
            starts  += int'(p_frame_start);
            check({nm, " frame_start"}, p_frame_start, 32'(k == 1));
            check({nm, " pre_ready"},   p_pre_ready,   32'(hs_done));
            check({nm, " busy"},        p_busy,        32'(!hs_done));
            check({nm, " conv_vld"},    p_conv_vld,    32'(ci < nc));
            check({nm, " fc_vld"},      p_fc_vld,      32'(ci == nc && fi < nf));
            check({nm, " post_valid"},  p_post_valid,  32'(exp_post));
            check({nm, " vld exclusive"}, 32'(p_conv_vld[0] && p_fc_vld[0]), 0);
            if (ci < nc) begin
                check({nm, " conv_row"}, p_row, 32'(ci / ow));
                check({nm, " conv_col"}, p_col, 32'(ci % ow));
            end else if (fi < nf) begin
                check({nm, " fc_neuron"}, p_n, 32'(fi / nfeat));
                check({nm, " fc_feat"},   p_f, 32'(fi % nfeat));
                check({nm, " fc_first"},  p_fc_first, 32'(fi % nfeat == 0));
                check({nm, " fc_last"},   p_fc_last,  32'(fi % nfeat == nfeat - 1));
            end
            if (p_post_valid === 32'd1) begin
                post_cnt++;
                if (first_post_k < 0) first_post_k = k;
            end
            if (hs_done) begin
                finished = 1;
                break;
            end
            if (abort_fi >= 0 && ci == nc && fi == abort_fi) begin
                #2 rst = 1'b1;
                #1 check_reset_vals({nm, " async reset"});
                #1 rst = 1'b0;
                pre_valid = 1'b0; conv_rdy = 1'b0; fc_rdy = 1'b0; post_ready = 1'b0;
                return;
            end
            // Stimulus for the next edge, then advance the model by what the
            // edge will accept.
            conv_rdy   = ($urandom_range(99) < 32'(pct));
            fc_rdy     = ($urandom_range(99) < 32'(pct));
            post_ready = exp_post && (post_cnt > post_stall);
            if (ci < nc) begin
                if (conv_rdy) ci++;
            end else if (fi < nf) begin
                if (fc_rdy) begin
                    firsts += int'(p_fc_first);
                    lasts  += int'(p_fc_last);
                    fi++;
                end
            end else if (post_ready) begin
                hs_done = 1;
            end
        end
        pre_valid  = 1'b0;
        post_ready = 1'b0;

        if (!finished) begin
            check({nm, " completed within cycle budget"}, 0, 1);
        end else begin
            check({nm, " frame_start pulses"}, 32'(starts), 1);
            check({nm, " conv beats"}, 32'(ci), 32'(nc));
            check({nm, " fc beats"},   32'(fi), 32'(nf));
            check({nm, " fc_first count"}, 32'(firsts), 32'(nout));
            check({nm, " fc_last count"},  32'(lasts),  32'(nout));
            check({nm, " post_valid cycles"}, 32'(post_cnt), 32'(post_stall + 1));
            // Sample k follows edge E(k-1), so edges after accept = k-1.
            if (pct == 100)
                check({nm, " post latency edges"}, 32'(first_post_k - 1), 32'(nc + nf));
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        sel = 1'b0; rst = 1'b1;
        pre_valid = 1'b1; post_ready = 1'b0; conv_rdy = 1'b1; fc_rdy = 1'b1;
        #2 check_reset_vals("reset");
        #13 rst = 1'b0;
        pre_valid = 1'b0;
        @(negedge clk);

        run_frame("s1 full-rate",   B_OW, B_NOUT, 100, 0,  -1);
        run_frame("s2 random-rdy",  B_OW, B_NOUT, 50,  0,  -1);
        run_frame("s4 post-stall",  B_OW, B_NOUT, 100, 20, -1);
        run_frame("s4 back-to-back", B_OW, B_NOUT, 100, 0, -1);
        run_frame("s5 abort",       B_OW, B_NOUT, 100, 0,  4 * B_NF + 300);
        @(negedge clk);
        check_reset_vals("s5 idle after abort");
        run_frame("s5 restart",     B_OW, B_NOUT, 100, 0,  -1);

        // Switch to the small instance from a clean reset.
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        #1 check_reset_vals("s6 small reset");
        run_frame("s6 small",        S_OW, S_NOUT, 100, 0, -1);
        run_frame("s6 small random", S_OW, S_NOUT, 50,  3, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
